wb_trace_buffer: RTL

- Synthesizable on-chip trace capture for the skeleton processor; it replaces ad-hoc probing of regfile, writeback and dmem signals with a bounded, triggerable event log.
- Monitors NUM_CH write-event channels: by convention, ch0 is regfile writeback (ctrl_writeEnable/ctrl_writeReg/data_writeReg) and ch1 is dmem store (wren/address_dmem/data).
- Stores timestamped events in a circular buffer with PC-match trigger, post-trigger count and cycle timeout.
- Drains captured events oldest-first over a valid/ready port.

---
 rtl/wb_trace_buffer_pkg.sv | 24 ++
 rtl/wb_trace_buffer_ring.sv | 48 ++++
 rtl/wb_trace_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared encodings for the trace buffer: FSM states, entry field widths, channel ids.
package wb_trace_buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_TRIGGERED = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam int CH_W   = 3;
  localparam int MAX_CH = 8;

  localparam logic [CH_W-1:0] CH_REGWB = 3'd0;
  localparam logic [CH_W-1:0] CH_DMEM  = 3'd1;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_ring.sv
// Circular event store; head is the oldest entry, a full ring overwrites its oldest entry.
// Write and pop are never requested together by the top level; clear wins over both.
module trace_ring #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdat,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_head_idx;

  // When full, count's low bits are zero so the head lands on wr_ptr (the oldest slot).
  assign w_head_idx = r_wr_ptr - r_count[PTR_W-1:0];
  assign o_head     = r_mem[w_head_idx];
  assign o_count    = r_count;

  always_ff @(posedge clock) begin
    if (i_wr && !i_clr) r_mem[r_wr_ptr] <= i_wdat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_wr) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (r_count != CNT_FULL) r_count <= r_count + (PTR_W + 1)'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_count <= r_count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Triggerable trace capture over NUM_CH write-event channels, drained oldest-first.
// FSM, lowest-channel arbitration, timestamp and drop counters; storage lives in trace_ring.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 16,
  parameter int NUM_CH  = 2,
  parameter int TS_W    = 16,
  parameter int POST    = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_pc_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_CH-1:0]        ev_valid,
  input  logic [NUM_CH*ADDR_W-1:0] ev_addr,
  input  logic [NUM_CH*DATA_W-1:0] ev_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CH_W-1:0]          rd_ch,
  output logic [TS_W-1:0]          rd_ts,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic                     timed_out,
  output logic [7:0]               dropped
);
  localparam int ENT_W = CH_W + TS_W + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PL_W  = (POST < 1) ? 1 : $clog2(POST + 1);
  localparam logic [PL_W-1:0] POST_L     = PL_W'(POST);
  localparam logic [TS_W-1:0] TIMEOUT_TS = TS_W'(TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [TS_W-1:0]    r_ts;
  logic [PL_W-1:0]    r_post_left, w_post_nxt;
  logic               r_triggered, r_timed_out;
  logic [7:0]         r_dropped;

  logic               w_any, w_active, w_capture, w_trig_hit, w_timeout_hit, w_pop;
  logic [CH_W-1:0]    w_sel;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [MAX_CH-1:0]  w_ev8;
  logic [3:0]         w_pop_cnt;
  logic [8:0]         w_drop_sum;
  logic [ENT_W-1:0]   w_wdat, w_head;
  logic [CNT_W-1:0]   w_count;

  // Scan high to low so the lowest-index valid channel is the one left selected.
  always_comb begin
    w_sel      = CH_REGWB;
    w_any      = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev_valid[i]) begin
        w_sel      = CH_W'(i);
        w_any      = 1'b1;
        w_sel_addr = ev_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = ev_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_ev8 = '0;
    w_ev8[NUM_CH-1:0] = ev_valid;
  end

  assign w_pop_cnt  = popcnt8(w_ev8);
  assign w_drop_sum = {1'b0, r_dropped} + {5'b00000, w_pop_cnt} - 9'd1;
  assign w_active   = (r_state == S_ARMED) || (r_state == S_TRIGGERED);
  assign w_capture  = w_active && w_any;
  assign w_wdat     = {w_sel, r_ts, w_sel_addr, w_sel_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_post_nxt    = r_post_left;
    w_trig_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    if (w_active) begin
      w_timeout_hit = (r_ts == TIMEOUT_TS);
      if (r_state == S_ARMED) begin
        if (trig_pc_en && (pc == trig_pc)) begin
          w_trig_hit  = 1'b1;
          w_post_nxt  = POST_L;
          w_state_nxt = (POST == 0) ? S_DONE : S_TRIGGERED;
        end
      end else if (w_any) begin
        w_post_nxt = r_post_left - PL_W'(1);
        if (r_post_left == PL_W'(1)) w_state_nxt = S_DONE;
      end
      if (w_timeout_hit) w_state_nxt = S_DONE;
    end
    if (arm) w_state_nxt = S_ARMED;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ts        <= '0;
      r_post_left <= '0;
      r_triggered <= 1'b0;
      r_timed_out <= 1'b0;
      r_dropped   <= '0;
    end else if (arm) begin
      r_ts        <= '0;
      r_post_left <= '0;
      r_triggered <= 1'b0;
      r_timed_out <= 1'b0;
      r_dropped   <= '0;
    end else begin
      if (w_active && (r_ts != '1)) r_ts <= r_ts + TS_W'(1);
      if (w_capture) r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_trig_hit) r_triggered <= 1'b1;
      if (w_timeout_hit) r_timed_out <= 1'b1;
      r_post_left <= w_post_nxt;
    end
  end

  assign rd_valid = (r_state == S_DONE) && (w_count != '0);
  assign w_pop    = rd_valid && rd_ready && !arm;

  trace_ring #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (arm),
    .i_wr    (w_capture),
    .i_pop   (w_pop),
    .i_wdat  (w_wdat),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign {rd_ch, rd_ts, rd_addr, rd_data} = w_head;
  assign state     = r_state;
  assign triggered = r_triggered;
  assign timed_out = r_timed_out;
  assign dropped   = r_dropped;

endmodule
